// File: rtl/manta_pkg.sv
// Shared definitions for the manta-style pipeline memory stage:
// opcode constants, the memory-stage state encoding and a writeback helper.
package manta_pkg;

   localparam logic [3:0] OP_LOAD  = 4'hb;
   localparam logic [3:0] OP_STORE = 4'hc;
   localparam logic [3:0] OP_NOWB  = 4'hd;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_e;

   // Every opcode except stores and explicit no-writeback ops writes rd.
   function automatic logic writes_rd(input logic [3:0] opcode);
      return !((opcode == OP_STORE) || (opcode == OP_NOWB));
   endfunction

   function automatic logic is_mem_op(input logic [3:0] opcode);
      return (opcode == OP_LOAD) || (opcode == OP_STORE);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/acknowledge bus between the memory stage (master)
// and the data cache (slave).
interface mem_stage_if;

   logic        dc_req;
   logic        dc_we;
   logic [15:0] dc_addr;
   logic [15:0] dc_wdata;
   logic        dc_ack;
   logic [15:0] dc_rdata;

   modport master (
      output dc_req, dc_we, dc_addr, dc_wdata,
      input  dc_ack, dc_rdata
   );

   modport slave (
      input  dc_req, dc_we, dc_addr, dc_wdata,
      output dc_ack, dc_rdata
   );

endinterface

// File: rtl/mem_watchdog.sv
// Busy-cycle watchdog for the memory stage. Counts consecutive cycles the
// stage spends waiting on the cache and flags the cycle in which the wait
// reaches TIMEOUT_CYCLES. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic busy_i,
   output logic expire_o
);

   // cnt_q holds the number of busy cycles already completed, so the
   // current busy cycle is number cnt_q + 1.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Count while busy, restart from zero whenever the stage is idle.
   always_comb begin
      cnt_d = 8'd0;
      if (busy_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = busy_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 16-bit manta-style pipeline (between EX and WB).
// ALU / no-writeback ops pass through in one cycle; loads and stores run a
// req/ack transaction on the data cache and stall EX until it completes.
// Optional feature: define MEM_TIMEOUT_EN to abort cache waits after
// TIMEOUT_CYCLES busy cycles and raise the sticky mem_err flag.
module mem_stage
   import manta_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ex_valid,
   input  logic [15:0]        ex_instr,
   input  logic [15:0]        ex_alu_out,
   input  logic [15:0]        ex_store_data,
   output logic               mem_stall,
   output logic [3:0]         hc_mem_rd,
   mem_stage_if.master        dc,
   output logic               wb_valid,
   output logic [15:0]        wb_instr,
   output logic [15:0]        wb_result,
   output logic               wb_wr_en,
   output logic               mem_err
);

   mem_state_e  state_q, state_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        wb_valid_q, wb_valid_d;
   logic [15:0] wb_instr_q, wb_instr_d;
   logic [15:0] wb_result_q, wb_result_d;
   logic        wb_wr_en_q, wb_wr_en_d;

   logic [3:0]  ex_op;
   logic        busy;
   logic        busy_is_load;
   logic        timeout_abort;

   assign ex_op        = ex_instr[15:12];
   assign busy         = (state_q == BUSY);
   assign busy_is_load = (instr_q[15:12] == OP_LOAD);

`ifdef MEM_TIMEOUT_EN
   logic expire;
   logic mem_err_q;

   mem_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .busy_i   (busy),
      .expire_o (expire)
   );

   // An ack in the expiry cycle completes normally, so it masks the abort.
   assign timeout_abort = busy && expire && !dc.dc_ack;

   // Sticky error flag: set by a watchdog abort, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_err_q <= 1'b0;
      end else if (timeout_abort) begin
         mem_err_q <= 1'b1;
      end
   end

   assign mem_err = mem_err_q;
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT_CYCLES);
   assign timeout_abort  = 1'b0;
   assign mem_err        = 1'b0;
`endif

   // Next-state and retire logic: accept in IDLE, wait for ack in BUSY.
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      wb_valid_d  = 1'b0;
      wb_instr_d  = wb_instr_q;
      wb_result_d = wb_result_q;
      wb_wr_en_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (is_mem_op(ex_op)) begin
                  state_d = BUSY;
                  instr_d = ex_instr;
                  addr_d  = ex_alu_out;
                  wdata_d = ex_store_data;
                  we_d    = (ex_op == OP_STORE);
               end else begin
                  wb_valid_d  = 1'b1;
                  wb_instr_d  = ex_instr;
                  wb_result_d = ex_alu_out;
                  wb_wr_en_d  = writes_rd(ex_op);
               end
            end
         end
         BUSY: begin
            if (dc.dc_ack) begin
               state_d     = IDLE;
               wb_valid_d  = 1'b1;
               wb_instr_d  = instr_q;
               wb_result_d = busy_is_load ? dc.dc_rdata : addr_q;
               wb_wr_en_d  = busy_is_load;
            end else if (timeout_abort) begin
               state_d     = IDLE;
               wb_valid_d  = 1'b1;
               wb_instr_d  = instr_q;
               wb_result_d = 16'hFFFF;
               wb_wr_en_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, latched transaction and writeback registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         instr_q     <= 16'h0000;
         addr_q      <= 16'h0000;
         wdata_q     <= 16'h0000;
         we_q        <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_instr_q  <= 16'h0000;
         wb_result_q <= 16'h0000;
         wb_wr_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         wb_valid_q  <= wb_valid_d;
         wb_instr_q  <= wb_instr_d;
         wb_result_q <= wb_result_d;
         wb_wr_en_q  <= wb_wr_en_d;
      end
   end

   // Hazard view: the incoming rd while idle, the latched load rd while busy.
   always_comb begin
      hc_mem_rd = 4'd0;
      if (busy) begin
         if (busy_is_load) begin
            hc_mem_rd = instr_q[3:0];
         end
      end else if (ex_valid && writes_rd(ex_op)) begin
         hc_mem_rd = ex_instr[3:0];
      end
   end

   assign mem_stall   = busy;
   assign dc.dc_req   = busy;
   assign dc.dc_we    = we_q;
   assign dc.dc_addr  = addr_q;
   assign dc.dc_wdata = wdata_q;

   assign wb_valid  = wb_valid_q;
   assign wb_instr  = wb_instr_q;
   assign wb_result = wb_result_q;
   assign wb_wr_en  = wb_wr_en_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the manta_style 5-stage, 16-bit pipeline. Sits between EX and WB. Accepts one instruction per cycle from EX and passes ALU results through in one cycle. Loads and stores run a req/ack transaction with the data cache, stalling upstream until it completes. Also supplies the in-stage destination register to hazard control.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: cycles dc_req may stay high without dc_ack before abort; legal range 1..255; used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ex_valid  input  1  EX presents a valid instruction
- ex_instr  input  16  instruction; [15:12] opcode, [3:0] rd
- ex_alu_out  input  16  ALU result; the byte-agnostic word address for load/store
- ex_store_data  input  16  store data (rs2 value)
- mem_stall  output  1  stage busy; EX must hold all ex_* inputs stable
- hc_mem_rd  output  4  rd of the instruction held in the stage; 0 if none or no writeback
- dc_req  output  1  cache request
- dc_we  output  1  1 = store, 0 = load
- dc_addr  output  16  cache word address
- dc_wdata  output  16  store data
- dc_ack  input  1  cache completion; single-cycle pulse
- dc_rdata  input  16  load data; valid when dc_ack = 1
- wb_valid  output  1  one-cycle retire pulse into WB
- wb_instr  output  16  retiring instruction
- wb_result  output  16  ALU result, or load data for loads
- wb_wr_en  output  1  register-file write enable
- mem_err  output  1  sticky timeout flag

## Operation
- Opcodes come from manta_pkg:
  - OP_LOAD = 4'hb
  - OP_STORE = 4'hc
  - OP_NOWB = 4'hd
  - All other opcodes are ALU ops with writeback.
- An instruction is accepted on a rising edge where ex_valid = 1 and mem_stall = 0.
- FSM states:
  - IDLE:
    - Accepting ALU or OP_NOWB goes to IDLE. wb_* is registered on that edge.
    - Accepting load/store goes to BUSY. Instruction, address, store data and rd are latched.
    - With no accept, wb_valid = 0.
  - BUSY:
    - dc_req = 1. dc_we, dc_addr and dc_wdata are held constant.
    - On dc_ack, go to IDLE. wb_valid = 1 on that edge.
    - For a load, wb_result = dc_rdata and wb_wr_en = 1.
    - For a store, wb_result = address and wb_wr_en = 0.
- wb_wr_en = 0 for OP_STORE and OP_NOWB.
- mem_stall = (state == BUSY), combinational. No accept is possible in the ack cycle.
- hc_mem_rd:
  - In IDLE, it is ex_instr[3:0] when ex_valid is high and the opcode writes back, else 0.
  - In BUSY, it is the latched load's rd; for a store it is 0.
- dc_ack seen while IDLE is ignored.
- Reset values:
  - state = IDLE
  - dc_req, dc_we, wb_valid, wb_wr_en, mem_err = 0
  - dc_addr, dc_wdata, wb_instr, wb_result = 0
- rst_n asserted mid-transaction drops dc_req immediately and abandons the access. No retire occurs.

## Timing
- ALU/NOWB accepted at edge N: wb_valid high in cycle N+1 for one cycle.
- Load/store accepted at edge N: dc_req rises in cycle N+1, and mem_stall is high from N+1.
  - The earliest dc_ack is in cycle N+1. wb_valid is then high in N+2, and mem_stall is low in N+2.
  - Total latency is 2 + (cache wait cycles).
- Back-to-back ALU instructions sustain 1 per cycle. A load followed immediately by an ALU instruction costs at least one stall cycle.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter counts cycles while in BUSY.
  - When the count reaches TIMEOUT_CYCLES without dc_ack, dc_req drops and the state returns to IDLE.
  - wb_valid pulses with wb_wr_en = 0 and wb_result = 16'hFFFF.
  - mem_err sets and stays set until reset.
  - dc_ack arriving in the same cycle as the timeout wins: normal completion, no error.
- MEM_TIMEOUT_EN undefined: there is no counter, mem_err is tied 0, and BUSY waits indefinitely.

## Structure
- manta_pkg holds:
  - opcode constants OP_LOAD, OP_STORE, OP_NOWB
  - the mem-stage state enum (IDLE, BUSY)
  - helper function writes_rd(opcode)
- Sub-module mem_watchdog (counter plus compare) is instantiated only under MEM_TIMEOUT_EN. Everything else is flat.

## Test plan
- ALU stream: instructions 16'h1123, 16'h2234 with ALU out 5, 7 in consecutive cycles -> wb_valid two consecutive cycles, wb_result 5 then 7, wb_wr_en = 1, mem_stall never high.
- Load, 3-cycle cache: instr 16'hb105, addr 16'h0040, dc_ack in the 3rd BUSY cycle with dc_rdata 16'hBEEF -> dc_req high 3 cycles with addr 0x0040 stable, wb_result 0xBEEF, wb_wr_en = 1, hc_mem_rd = 5 throughout.
- Store, 0-wait: instr 16'hc012, addr 0x0010, data 0x1234, ack in first BUSY cycle -> dc_we = 1, dc_wdata 0x1234, wb_valid in N+2 with wb_wr_en = 0, hc_mem_rd = 0.
- Stall hold: ALU instruction presented during load BUSY -> not accepted until the cycle after ack; it retires the cycle after the load retires.
- Reset mid-load: rst_n low in the 2nd BUSY cycle -> dc_req drops the same cycle, no wb_valid. After release, a late dc_ack is ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, ack never comes: dc_req high 4 cycles, then wb_valid with wb_result 0xFFFF and wb_wr_en = 0, mem_err = 1 sticky.
